data_sram_responder: RTL and testbench

- Simulation/FPGA-side responder for the CPU's sram-like data port.
- Accepts CPU load/store requests that carry a byte strobe and a lane-shifted write data word.
- Keeps up to DEPTH requests outstanding and answers them in order after a fixed LATENCY. Each response carries the full 32-bit word; the CPU does byte/half selection and extension itself.
- Also flags size/address misalignment, mirroring the CPU's own address-exception check from the memory side.

---
 rtl/data_sram_if.sv | 26 ++
 rtl/data_sram_responder.sv | 126 ++++++++++++
 tb/tb_data_sram_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_if.sv
`timescale 1ns/1ps
// CPU sram-like data port bundle: request side (req/wr/size/addr/wstrb/wdata)
// and response side (addr_ok/data_ok/rdata/err).
// master = CPU side, slave = memory responder side.
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/data_sram_responder.sv
`timescale 1ns/1ps
// In-order memory responder for the CPU sram-like data port, with misalignment flagging.
// Latency: a request accepted at edge E retires at edge E+LATENCY (registered data_ok/rdata/err).
// Backpressure: addr_ok = !full from queue state only; a pop does not free a slot in the same cycle.
// Ports: clk, rst (sync, active-high), bus (data_sram_if.slave).
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  data_sram_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              err;
    logic [3:0]        cnt;
  } entry_t;

  entry_t          q_q [DEPTH];
  entry_t          q_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            data_ok_q, data_ok_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  // Backing store; contents deliberately survive reset.
  logic [31:0]     mem [2**ADDR_W];

  entry_t          head;
  logic            addr_ok_w;
  logic            push;
  logic            pop;
  logic            req_err;

  // Address bits above the memory index are don't-care.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  assign addr_ok_w   = (count_q != CW'(DEPTH));
  assign bus.addr_ok = addr_ok_w;
  assign bus.data_ok = data_ok_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;

  always_comb begin
    req_err = (bus.size == 2'd3)
           || (bus.size == 2'd1 && bus.addr[0])
           || (bus.size == 2'd2 && bus.addr[1:0] != 2'b00)
           || (bus.wr && bus.wstrb == 4'b0000);

    head = q_q[rptr_q];
    push = bus.req && addr_ok_w;
    pop  = (count_q != '0) && (head.cnt == 4'd0);

    // Every slot counts down, not only the head, so a run of queued
    // requests drains on consecutive edges once the head expires.
    q_d = q_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_q[i].cnt != 4'd0) q_d[i].cnt = q_q[i].cnt - 4'd1;
    end

    // Push cannot hit the head slot: push needs a free slot, so wptr != rptr
    // whenever the queue is non-empty.
    if (push) begin
      q_d[wptr_q].wr    = bus.wr;
      q_d[wptr_q].idx   = bus.addr[ADDR_W+1:2];
      q_d[wptr_q].wstrb = bus.wstrb;
      q_d[wptr_q].wdata = bus.wdata;
      q_d[wptr_q].err   = req_err;
      q_d[wptr_q].cnt   = 4'(LATENCY - 1);
    end

    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);

    data_ok_d = pop;
    err_d     = pop && head.err;
    rdata_d   = rdata_q;
    if (pop) begin
      // Async read sees the word before any same-edge store retires.
      rdata_d = (!head.wr && !head.err) ? mem[head.idx] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      q_q       <= q_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      data_ok_q <= data_ok_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Byte-masked store on retirement; a reset edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && pop && head.wr && !head.err) begin
      for (int b = 0; b < 4; b++) begin
        if (head.wstrb[b]) mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
`timescale 1ns/1ps
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;

  data_sram_if a_if ();
  data_sram_if b_if ();
  data_sram_if c_if ();

  data_sram_responder #(.ADDR_W(10), .LATENCY(2), .DEPTH(4)) dut_a (.clk(clk), .rst(rst_a), .bus(a_if));
  data_sram_responder #(.ADDR_W(10), .LATENCY(4), .DEPTH(4)) dut_b (.clk(clk), .rst(rst_b), .bus(b_if));
  data_sram_responder #(.ADDR_W(10), .LATENCY(1), .DEPTH(4)) dut_c (.clk(clk), .rst(rst_c), .bus(c_if));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single request on dut_a: held for exactly one edge.
  task automatic a_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [3:0] wstrb, input logic [31:0] wdata);
    a_if.req = 1'b1; a_if.wr = wr; a_if.size = size; a_if.addr = addr;
    a_if.wstrb = wstrb; a_if.wdata = wdata;
    step();
    a_if.req = 1'b0;
  endtask

  // Bounded wait for the next dut_a response; consumes the response cycle.
  task automatic a_wait(input string tag, output logic [31:0] rd, output logic er);
    int i = 0;
    while (a_if.data_ok !== 1'b1 && i < 20) begin
      step();
      i++;
    end
    chk({tag, "_resp"}, {31'h0, a_if.data_ok}, 32'h1);
    rd = a_if.rdata;
    er = a_if.err;
    step();
  endtask

  logic [31:0] rd;
  logic        er;
  logic [6:0]  exp_aok;
  logic [11:0] exp_dok;
  int          idx, resp, k;
  logic        seen;

  initial begin
    a_if.req = 0; a_if.wr = 0; a_if.size = 0; a_if.addr = 0; a_if.wstrb = 0; a_if.wdata = 0;
    b_if.req = 0; b_if.wr = 0; b_if.size = 0; b_if.addr = 0; b_if.wstrb = 0; b_if.wdata = 0;
    c_if.req = 0; c_if.wr = 0; c_if.size = 0; c_if.addr = 0; c_if.wstrb = 0; c_if.wdata = 0;
    rst_a = 1; rst_b = 1; rst_c = 1;
    step(); step();
    rst_a = 0; rst_b = 0; rst_c = 0;

    // Reset state
    chk("rst_addr_ok", {31'h0, a_if.addr_ok}, 32'h1);
    chk("rst_data_ok", {31'h0, a_if.data_ok}, 32'h0);
    chk("rst_rdata",   a_if.rdata, 32'h0);
    chk("rst_err",     {31'h0, a_if.err}, 32'h0);
    chk("rst_b_addr_ok", {31'h0, b_if.addr_ok}, 32'h1);

    // 1: store then load back-to-back, LATENCY=2
    a_if.req = 1; a_if.wr = 1; a_if.size = 2; a_if.addr = 32'h10; a_if.wstrb = 4'hF; a_if.wdata = 32'hDEADBEEF;
    step();
    chk("t1_e0_data_ok", {31'h0, a_if.data_ok}, 32'h0);
    a_if.wr = 0; a_if.wstrb = 4'h0; a_if.wdata = 32'h0;
    step();
    chk("t1_e1_data_ok", {31'h0, a_if.data_ok}, 32'h0);
    a_if.req = 0;
    step();
    chk("t1_st_data_ok", {31'h0, a_if.data_ok}, 32'h1);
    chk("t1_st_rdata",   a_if.rdata, 32'h0);
    chk("t1_st_err",     {31'h0, a_if.err}, 32'h0);
    step();
    chk("t1_ld_data_ok", {31'h0, a_if.data_ok}, 32'h1);
    chk("t1_ld_rdata",   a_if.rdata, 32'hDEADBEEF);
    chk("t1_ld_err",     {31'h0, a_if.err}, 32'h0);
    step();
    chk("t1_idle_data_ok", {31'h0, a_if.data_ok}, 32'h0);
    chk("t1_rdata_hold",   a_if.rdata, 32'hDEADBEEF);

    // 2: byte/half merge into a word
    a_req(1, 2, 32'h20, 4'b1111, 32'h11223344); a_wait("t2_sw", rd, er);
    a_req(1, 0, 32'h22, 4'b0100, 32'h00AA0000); a_wait("t2_sb", rd, er);
    chk("t2_sb_err", {31'h0, er}, 32'h0);
    a_req(1, 1, 32'h20, 4'b0011, 32'h00005566); a_wait("t2_sh", rd, er);
    chk("t2_sh_err", {31'h0, er}, 32'h0);
    a_req(0, 2, 32'h20, 4'b0000, 32'h0); a_wait("t2_lw", rd, er);
    chk("t2_merged", rd, 32'h11AA5566);
    chk("t2_lw_err", {31'h0, er}, 32'h0);

    // 4: misalignment and illegal requests
    a_req(0, 2, 32'h22, 4'b0000, 32'h0); a_wait("t4_lw_mis", rd, er);
    chk("t4_lw_mis_err", {31'h0, er}, 32'h1);
    chk("t4_lw_mis_rdata", rd, 32'h0);
    a_req(1, 2, 32'h30, 4'b1111, 32'hCAFEF00D); a_wait("t4_sw", rd, er);
    chk("t4_sw_err", {31'h0, er}, 32'h0);
    a_req(1, 1, 32'h31, 4'b0110, 32'hFFFFFFFF); a_wait("t4_sh_mis", rd, er);
    chk("t4_sh_mis_err", {31'h0, er}, 32'h1);
    chk("t4_sh_mis_rdata", rd, 32'h0);
    a_req(1, 2, 32'h30, 4'b0000, 32'h0); a_wait("t4_nostrb", rd, er);
    chk("t4_nostrb_err", {31'h0, er}, 32'h1);
    a_req(0, 3, 32'h30, 4'b0000, 32'h0); a_wait("t4_size3", rd, er);
    chk("t4_size3_err", {31'h0, er}, 32'h1);
    chk("t4_size3_rdata", rd, 32'h0);
    a_req(0, 2, 32'h30, 4'b0000, 32'h0); a_wait("t4_lw", rd, er);
    chk("t4_old_word", rd, 32'hCAFEF00D);
    chk("t4_lw_err", {31'h0, er}, 32'h0);

    // 3: back-pressure, DEPTH=4 LATENCY=4; burst 0 stores, burst 1 loads them back
    exp_aok = 7'b1101111;
    exp_dok = 12'b011011110000;
    for (int bst = 0; bst < 2; bst++) begin
      idx = 0; resp = 0;
      for (int c = 0; c < 12; c++) begin
        if (idx < 6) begin
          b_if.req = 1; b_if.wr = (bst == 0); b_if.size = 2; b_if.addr = 32'(idx * 4);
          b_if.wstrb = (bst == 0) ? 4'hF : 4'h0; b_if.wdata = 32'hB0000000 + 32'(idx);
        end else begin
          b_if.req = 0;
        end
        if (c < 7) chk("t3_addr_ok", {31'h0, b_if.addr_ok}, {31'h0, exp_aok[c]});
        if (b_if.req && b_if.addr_ok) idx++;
        step();
        chk("t3_data_ok", {31'h0, b_if.data_ok}, {31'h0, exp_dok[c]});
        if (b_if.data_ok) begin
          chk("t3_rdata", b_if.rdata, (bst == 0) ? 32'h0 : 32'hB0000000 + 32'(resp));
          resp++;
        end
      end
      chk("t3_accepts", 32'(idx), 32'd6);
      chk("t3_responses", 32'(resp), 32'd6);
    end

    // 5: reset one edge before the first response on dut_b
    for (int c = 0; c < 3; c++) begin
      b_if.req = 1; b_if.wr = 0; b_if.size = 2; b_if.addr = 32'(c * 4); b_if.wstrb = 0;
      step();
    end
    b_if.req = 0;
    rst_b = 1;
    step();
    rst_b = 0;
    chk("t5_addr_ok", {31'h0, b_if.addr_ok}, 32'h1);
    chk("t5_data_ok", {31'h0, b_if.data_ok}, 32'h0);
    chk("t5_rdata",   b_if.rdata, 32'h0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      seen = seen | b_if.data_ok;
    end
    chk("t5_no_resp", {31'h0, seen}, 32'h0);
    b_if.req = 1; b_if.wr = 0; b_if.size = 2; b_if.addr = 32'hC;
    step();
    b_if.req = 0;
    k = 0;
    while (b_if.data_ok !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("t5_load_resp", {31'h0, b_if.data_ok}, 32'h1);
    chk("t5_mem_kept",  b_if.rdata, 32'hB0000003);
    step();

    // 6: LATENCY=1, loads every cycle
    c_if.req = 1; c_if.wr = 1; c_if.size = 2; c_if.addr = 32'h0; c_if.wstrb = 4'hF; c_if.wdata = 32'h12345678;
    step();
    c_if.req = 0;
    step();
    chk("t6_sw_data_ok", {31'h0, c_if.data_ok}, 32'h1);
    chk("t6_sw_err",     {31'h0, c_if.err}, 32'h0);
    step();
    for (int c = 0; c < 8; c++) begin
      c_if.req = 1; c_if.wr = 0; c_if.size = 2; c_if.addr = 32'h0; c_if.wstrb = 0;
      chk("t6_addr_ok_pre", {31'h0, c_if.addr_ok}, 32'h1);
      step();
      chk("t6_addr_ok", {31'h0, c_if.addr_ok}, 32'h1);
      if (c == 0) begin
        chk("t6_first_data_ok", {31'h0, c_if.data_ok}, 32'h0);
      end else begin
        chk("t6_data_ok", {31'h0, c_if.data_ok}, 32'h1);
        chk("t6_rdata",   c_if.rdata, 32'h12345678);
      end
    end
    c_if.req = 0;
    step();
    chk("t6_last_data_ok", {31'h0, c_if.data_ok}, 32'h1);
    step();
    chk("t6_drained", {31'h0, c_if.data_ok}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
